// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage interlock for the 5-stage MIPS pipeline.
// Detects hazards that EX forwarding cannot cover (load-use, load->branch,
// ALU->branch) and stalls PC/IF/ID while bubbling ID/EX. Multi-cycle stalls
// are held by a registered down-counter rather than re-evaluating hazards.
// Optional performance counters are compiled in with HAZARD_PERF_CNT_EN.

module hazard_stall_unit #(
    parameter int unsigned LOAD_USE_STALLS    = 1,
    parameter int unsigned LOAD_BRANCH_STALLS = 2,
    parameter int unsigned ALU_BRANCH_STALLS  = 1,
    parameter int unsigned CNT_W              = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IDRegRs,
    input  logic [4:0]  IDRegRt,
    input  logic        ID_UsesRt,
    input  logic        ID_Branch,
    input  logic        ID_Jump,
    input  logic        BranchTaken,
    input  logic [4:0]  EXRegRd,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic [4:0]  MEMRegRd,
    input  logic        MEM_MemRead,
    input  logic        Hold,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEX_Bubble,
    output logic        IFID_Flush,
    output logic        Stalling
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [0:0] {StRun, StStall} hazState_t;

    localparam logic [CNT_W-1:0] CntZero = '0;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] NLoadUse    = CNT_W'(LOAD_USE_STALLS);
    localparam logic [CNT_W-1:0] NLoadBranch = CNT_W'(LOAD_BRANCH_STALLS);
    localparam logic [CNT_W-1:0] NAluBranch  = CNT_W'(ALU_BRANCH_STALLS);

    hazState_t        stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;

    logic             exMatch, memMatch;
    logic             hazLoadBranch, hazLoadUse, hazAluBranch;
    logic [CNT_W-1:0] hazN;
    logic             hazard;

    // Hazard detection: register matches, class flags and the largest stall length
    always_comb begin
        exMatch  = (EXRegRd != 5'd0) &&
                   ((EXRegRd == IDRegRs) || (ID_UsesRt && (EXRegRd == IDRegRt)));
        memMatch = (MEMRegRd != 5'd0) &&
                   ((MEMRegRd == IDRegRs) || (ID_UsesRt && (MEMRegRd == IDRegRt)));

        // A zero stall count disables the class entirely
        hazLoadBranch = ID_Branch && EX_RegWrite && EX_MemRead && exMatch &&
                        (NLoadBranch != CntZero);
        hazLoadUse    = !ID_Branch && EX_RegWrite && EX_MemRead && exMatch &&
                        (NLoadUse != CntZero);
        hazAluBranch  = ID_Branch &&
                        ((EX_RegWrite && !EX_MemRead && exMatch) || (MEM_MemRead && memMatch)) &&
                        (NAluBranch != CntZero);

        hazN = CntZero;
        if (hazLoadUse && (NLoadUse > hazN)) begin
            hazN = NLoadUse;
        end
        if (hazAluBranch && (NAluBranch > hazN)) begin
            hazN = NAluBranch;
        end
        if (hazLoadBranch && (NLoadBranch > hazN)) begin
            hazN = NLoadBranch;
        end
        hazard = (hazN != CntZero);
    end

    // State and counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StRun;
            cntQ   <= CntZero;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Next-state: enter STALL for multi-cycle hazards, count down, freeze on Hold
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        if (!Hold) begin
            case (stateQ)
                StRun: begin
                    // Single-cycle hazards are fully covered by this cycle's stall
                    if (hazN > CntOne) begin
                        stateD = StStall;
                        cntD   = hazN - CntOne;
                    end
                end
                StStall: begin
                    if (cntQ <= CntOne) begin
                        stateD = StRun;
                        cntD   = CntZero;
                    end else begin
                        cntD = cntQ - CntOne;
                    end
                end
                default: begin
                    stateD = StRun;
                    cntD   = CntZero;
                end
            endcase
        end
    end

    // Outputs: reset beats Hold, Hold beats stalling, stalling beats flushing
    always_comb begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        Stalling    = 1'b0;
        if (reset) begin
            IDEX_Bubble = 1'b1;
        end else if (Hold) begin
            Stalling = (stateQ == StStall);
        end else if ((stateQ == StStall) || hazard) begin
            IDEX_Bubble = 1'b1;
            Stalling    = 1'b1;
        end else begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IFID_Flush = ID_Jump || (ID_Branch && BranchTaken);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Performance counters: stall cycles not masked by Hold, and issued flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles <= 32'd0;
            FlushCount  <= 32'd0;
        end else begin
            if (Stalling && !Hold) begin
                StallCycles <= StallCycles + 32'd1;
            end
            if (IFID_Flush) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: directed scenarios plus randomized traffic
// checked against a remaining-stall-cycles reference model.

module tb_hazard_stall_unit;

    localparam int LU = 1;
    localparam int LB = 2;
    localparam int AB = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  IDRegRs = '0, IDRegRt = '0, EXRegRd = '0, MEMRegRd = '0;
    logic        ID_UsesRt = 1'b0, ID_Branch = 1'b0, ID_Jump = 1'b0, BranchTaken = 1'b0;
    logic        EX_RegWrite = 1'b0, EX_MemRead = 1'b0, MEM_MemRead = 1'b0, Hold = 1'b0;
    logic        PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Stalling;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCycles, FlushCount;
    int unsigned mStall = 0, mFlush = 0;
`endif

    logic [4:0] dutOut;
    logic [4:0] exp;
    int vecs = 0;
    int errs = 0;
    int mRemain = 0;

    assign dutOut = {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Stalling};

    always #5 clk = ~clk;

    hazard_stall_unit dut (
        .clk         (clk),
        .reset       (reset),
        .IDRegRs     (IDRegRs),
        .IDRegRt     (IDRegRt),
        .ID_UsesRt   (ID_UsesRt),
        .ID_Branch   (ID_Branch),
        .ID_Jump     (ID_Jump),
        .BranchTaken (BranchTaken),
        .EXRegRd     (EXRegRd),
        .EX_RegWrite (EX_RegWrite),
        .EX_MemRead  (EX_MemRead),
        .MEMRegRd    (MEMRegRd),
        .MEM_MemRead (MEM_MemRead),
        .Hold        (Hold),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .IDEX_Bubble (IDEX_Bubble),
        .IFID_Flush  (IFID_Flush),
        .Stalling    (Stalling)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
`endif
    );

    // ---------------- reference model ----------------
    // Longest stall demanded by the current inputs (0 = none)
    function automatic int modelN();
        bit mEx, mMem;
        int n;
        n    = 0;
        mEx  = (EXRegRd != 0) && (EXRegRd == IDRegRs || (ID_UsesRt && EXRegRd == IDRegRt));
        mMem = (MEMRegRd != 0) && (MEMRegRd == IDRegRs || (ID_UsesRt && MEMRegRd == IDRegRt));
        if (ID_Branch && EX_RegWrite && EX_MemRead && mEx && LB > n) n = LB;
        if (!ID_Branch && EX_RegWrite && EX_MemRead && mEx && LU > n) n = LU;
        if (ID_Branch && ((EX_RegWrite && !EX_MemRead && mEx) || (MEM_MemRead && mMem))
            && AB > n) n = AB;
        return n;
    endfunction

    // {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, Stalling}
    function automatic logic [4:0] expOut();
        if (reset) return 5'b00100;
        if (Hold) return {4'b0000, mRemain > 0};
        if (mRemain > 0 || modelN() > 0) return 5'b00101;
        return {3'b110, ID_Jump || (ID_Branch && BranchTaken), 1'b0};
    endfunction

    function automatic int nextRemain();
        if (reset) return 0;
        if (Hold) return mRemain;
        if (mRemain > 0) return mRemain - 1;
        if (modelN() > 0) return modelN() - 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        mRemain <= nextRemain();
`ifdef HAZARD_PERF_CNT_EN
        if (reset) begin
            mStall <= 0;
            mFlush <= 0;
        end else begin
            if (!Hold && (mRemain > 0 || modelN() > 0)) mStall <= mStall + 1;
            if (!Hold && mRemain == 0 && modelN() == 0 && (ID_Jump || (ID_Branch && BranchTaken)))
                mFlush <= mFlush + 1;
        end
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                         input logic br, input logic jmp, input logic taken,
                         input logic [4:0] exRd, input logic exRw, input logic exMr,
                         input logic [4:0] memRd, input logic memMr,
                         input logic hold, input logic rst);
        IDRegRs = rs; IDRegRt = rt; ID_UsesRt = usesRt; ID_Branch = br; ID_Jump = jmp;
        BranchTaken = taken; EXRegRd = exRd; EX_RegWrite = exRw; EX_MemRead = exMr;
        MEMRegRd = memRd; MEM_MemRead = memMr; Hold = hold; reset = rst;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    // EX: lw $9; ID: beq $9,$1 taken
    task automatic loadBranch(input logic hold, input logic rst);
        drive(5'd9, 5'd1, 1, 1, 0, 1, 5'd9, 1, 1, 5'd0, 0, hold, rst);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk); drive(5'd3, 5'd3, 1, 1, 1, 1, 5'd3, 1, 1, 5'd3, 1, 1, 1); #1;
        vecs++;
        if (dutOut !== 5'b00100) begin
            errs++; $display("FAIL reset_outputs: got %b want %b", dutOut, 5'b00100);
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (dutOut !== 5'b11000) begin
            errs++; $display("FAIL reset_run_idle: got %b want %b", dutOut, 5'b11000);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk); drive(5'd8, 5'd2, 1, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0); #1;
        vecs++;
        if (dutOut !== 5'b00101) begin
            errs++; $display("FAIL load_use_stall: got %b want %b", dutOut, 5'b00101);
        end
        @(negedge clk); drive(5'd8, 5'd2, 1, 0, 0, 0, 5'd0, 0, 0, 5'd8, 1, 0, 0); #1;
        vecs++;
        if (dutOut !== 5'b11000) begin
            errs++; $display("FAIL load_use_release: got %b want %b", dutOut, 5'b11000);
        end
    endtask

    task automatic test_load_branch();
        @(negedge clk); loadBranch(0, 0); #1;
        vecs++;
        if (dutOut !== 5'b00101) begin
            errs++; $display("FAIL load_branch_c1: got %b want %b", dutOut, 5'b00101);
        end
        // Second stall cycle: load has moved to MEM, must be ignored while stalling
        @(negedge clk); drive(5'd9, 5'd1, 1, 1, 0, 1, 5'd0, 0, 0, 5'd9, 1, 0, 0); #1;
        vecs++;
        if (dutOut !== 5'b00101) begin
            errs++; $display("FAIL load_branch_c2: got %b want %b", dutOut, 5'b00101);
        end
        @(negedge clk); drive(5'd9, 5'd1, 1, 1, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0); #1;
        vecs++;
        if (dutOut !== 5'b11010) begin
            errs++; $display("FAIL load_branch_flush: got %b want %b", dutOut, 5'b11010);
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (dutOut !== 5'b11000) begin
            errs++; $display("FAIL load_branch_after: got %b want %b", dutOut, 5'b11000);
        end
    endtask

    task automatic test_zero_reg();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 1, 1, 5'd0, 1, 0, 0); #1;
            vecs++;
            if (dutOut !== 5'b11000) begin
                errs++; $display("FAIL zero_reg c%0d: got %b want %b", i, dutOut, 5'b11000);
            end
        end
    endtask

    task automatic test_rt_use();
        @(negedge clk); drive(5'd1, 5'd5, 0, 0, 0, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0); #1;
        vecs++;
        if (dutOut !== 5'b11000) begin
            errs++; $display("FAIL rt_unused: got %b want %b", dutOut, 5'b11000);
        end
        @(negedge clk); drive(5'd1, 5'd5, 1, 0, 0, 0, 5'd5, 1, 1, 5'd0, 0, 0, 0); #1;
        vecs++;
        if (dutOut !== 5'b00101) begin
            errs++; $display("FAIL rt_used: got %b want %b", dutOut, 5'b00101);
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (dutOut !== 5'b11000) begin
            errs++; $display("FAIL rt_used_release: got %b want %b", dutOut, 5'b11000);
        end
    endtask

    task automatic test_hold_mid_stall();
        @(negedge clk); loadBranch(0, 0); #1;
        vecs++;
        if (dutOut !== 5'b00101) begin
            errs++; $display("FAIL hold_first_stall: got %b want %b", dutOut, 5'b00101);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); loadBranch(1, 0); #1;
            vecs++;
            if (dutOut !== 5'b00001) begin
                errs++; $display("FAIL hold_frozen c%0d: got %b want %b", i, dutOut, 5'b00001);
            end
        end
        @(negedge clk); loadBranch(0, 0); #1;
        vecs++;
        if (dutOut !== 5'b00101) begin
            errs++; $display("FAIL hold_last_stall: got %b want %b", dutOut, 5'b00101);
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (dutOut !== 5'b11000) begin
            errs++; $display("FAIL hold_release: got %b want %b", dutOut, 5'b11000);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk); loadBranch(0, 0); #1;
        vecs++;
        if (dutOut !== 5'b00101) begin
            errs++; $display("FAIL rst_mid_first: got %b want %b", dutOut, 5'b00101);
        end
        @(negedge clk); loadBranch(0, 1); #1;
        vecs++;
        if (dutOut !== 5'b00100) begin
            errs++; $display("FAIL rst_mid_during: got %b want %b", dutOut, 5'b00100);
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (dutOut !== 5'b11000) begin
            errs++; $display("FAIL rst_mid_after: got %b want %b", dutOut, 5'b11000);
        end
`ifdef HAZARD_PERF_CNT_EN
        vecs++;
        if (StallCycles !== 32'd0 || FlushCount !== 32'd0) begin
            errs++;
            $display("FAIL rst_mid_perf: got stall=%0d flush=%0d want 0/0", StallCycles, FlushCount);
        end
`endif
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
            #1;
            exp = expOut();
            vecs++;
            if (dutOut !== exp) begin
                errs++; $display("FAIL random #%0d: got %b want %b", i, dutOut, exp);
            end
`ifdef HAZARD_PERF_CNT_EN
            if (!reset) begin
                vecs++;
                if (StallCycles !== mStall || FlushCount !== mFlush) begin
                    errs++;
                    $display("FAIL random_perf #%0d: got %0d/%0d want %0d/%0d", i,
                             StallCycles, FlushCount, mStall, mFlush);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_branch();
        test_zero_reg();
        test_rt_use();
        test_hold_mid_stall();
        test_reset_mid_stall();
        // Start random traffic from a known counter state
        @(negedge clk); drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Interlock counterpart to the EX-stage forwarding unit. It detects the hazards that forwarding cannot resolve and stalls or flushes the front of the 5-stage MIPS pipeline.
- Located in the ID stage. Drives PC and IF/ID write enables, the ID/EX bubble select, and the IF/ID flush.
- A registered stall counter holds multi-cycle stalls, e.g. load→branch-in-ID, without re-evaluating the hazard every cycle.

Parameters:
LOAD_USE_STALLS, 1, stall cycles when an ID instruction reads the destination of a load in EX
LOAD_BRANCH_STALLS, 2, stall cycles when an ID branch compares the destination of a load in EX
ALU_BRANCH_STALLS, 1, stall cycles when an ID branch compares the destination of an ALU op in EX or a load in MEM
CNT_W, 2, stall counter width; every *_STALLS value must be ≤ 2^CNT_W-1

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high
IDRegRs  in  5  rs field of the instruction in ID
IDRegRt  in  5  rt field of the instruction in ID
ID_UsesRt  in  1  instruction in ID reads rt (R-type, beq/bne, sw)
ID_Branch  in  1  instruction in ID is beq/bne, resolved in ID
ID_Jump  in  1  instruction in ID is j/jal/jr
BranchTaken  in  1  ID comparator result, valid when ID_Branch=1
EXRegRd  in  5  destination register of the EX instruction (after RegDst mux)
EX_RegWrite  in  1  EX instruction writes the register file
EX_MemRead  in  1  EX instruction is a load
MEMRegRd  in  5  destination register of the MEM instruction
MEM_MemRead  in  1  MEM instruction is a load
Hold  in  1  global freeze (memory wait); overrides everything except reset
PCWrite  out  1  PC register load enable
IFIDWrite  out  1  IF/ID register load enable
IDEX_Bubble  out  1  select zero control word into ID/EX (insert nop)
IFID_Flush  out  1  clear IF/ID on the next edge (squash fetched instruction)
Stalling  out  1  high in every cycle the unit is holding PC/IF/ID for a hazard

Behaviour:
- State: RUN / STALL, plus counter cnt[CNT_W-1:0]. Reset → RUN, cnt=0. Reset asserted mid-stall → RUN on the next edge; the stall is abandoned.
- Match rules: mEX = (EXRegRd!=0) && (EXRegRd==IDRegRs || (ID_UsesRt && EXRegRd==IDRegRt)). mMEM is the same using MEMRegRd. Register 0 never causes a hazard.
- Hazard classes, evaluated in RUN only. Priority: highest N wins.
  - LB: ID_Branch && EX_RegWrite && EX_MemRead && mEX → N=LOAD_BRANCH_STALLS.
  - LU: !ID_Branch && EX_RegWrite && EX_MemRead && mEX → N=LOAD_USE_STALLS.
  - AB: ID_Branch && ((EX_RegWrite && !EX_MemRead && mEX) || (MEM_MemRead && mMEM)) → N=ALU_BRANCH_STALLS.
- Stall cycle outputs (combinational, same cycle as detection): PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0, Stalling=1.
- RUN with hazard N≥1:
  - Stall this cycle.
  - If N>1: go to STALL with cnt=N-1.
  - If N==1: stay in RUN.
- STALL:
  - Stall unconditionally; hazard inputs are ignored.
  - cnt decrements each edge. When cnt==1 at the edge → RUN, cnt=0.
  - On return to RUN, hazards are re-evaluated normally.
- RUN, no hazard:
  - PCWrite=1, IFIDWrite=1, IDEX_Bubble=0, Stalling=0.
  - IFID_Flush = ID_Jump || (ID_Branch && BranchTaken).
  - BranchTaken is ignored in any cycle where a hazard is detected or the unit is in STALL; no flush occurs while stalling.
- Hold=1:
  - PCWrite=0, IFIDWrite=0, IDEX_Bubble=0, IFID_Flush=0.
  - State and cnt are frozen. Stalling reflects the frozen state: 1 if in STALL, else 0.
- reset=1 (output values during reset): PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0, Stalling=0.
- *_STALLS=0 disables that hazard class.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Extra outputs StallCycles[31:0] and FlushCount[31:0].
  - StallCycles increments on each edge where Stalling=1 and Hold=0.
  - FlushCount increments on each edge where IFID_Flush=1.
  - Both counters clear on reset and wrap modulo 2^32.
- Undefined: no extra ports, registers or logic.

Test Plan:
- Load-use: EX lw rd=8 (EX_MemRead=1, EX_RegWrite=1); ID add rs=8 → one cycle with PCWrite=0/IFIDWrite=0/IDEX_Bubble=1; next cycle (EXRegRd=0 bubble) PCWrite=1.
- Load→branch: EX lw rd=9; ID beq rs=9 → Stalling=1 for exactly 2 cycles (state STALL, cnt=1); then RUN, BranchTaken=1 → IFID_Flush=1 for 1 cycle.
- Zero register: EX lw rd=0; ID add rs=0 → no stall, PCWrite=1 throughout.
- rt not used: EX lw rd=5; ID addi rt=5 with ID_UsesRt=0 → no stall. Same with ID_UsesRt=1 → 1-cycle stall.
- Hold mid-stall: trigger LB, assert Hold for 3 cycles after the first stall cycle → all enables 0, cnt frozen at 1; after release, exactly 1 more stall cycle.
- Reset mid-stall: trigger LB, assert reset for 1 cycle during STALL → state RUN, cnt=0. With HAZARD_PERF_CNT_EN defined, StallCycles=0 and FlushCount=0 after reset.
